// File: rtl/addr_seq_gen.sv
// rtl/addr_seq_gen.sv - table-based strided, bank-wrapping address burst generator
// Optional zero-bubble burst chaining: define ADDR_SEQ_GEN_B2B_EN.
module addr_seq_gen #(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 2,
  parameter int IDX_W  = 4,
  parameter int LEN_W  = 10,
  parameter int STR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IDX_W-1:0]  cmd_idx,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [STR_W-1:0]  cmd_stride,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic              busy
);

  localparam int OFF_W = ADDR_W - BANK_W;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] table_q [DEPTH];
  logic [ADDR_W-1:0] table_d [DEPTH];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [STR_W-1:0]  stride_q, stride_d;
  logic              addr_valid_q, addr_valid_d;
  logic              addr_last_q, addr_last_d;

  logic              beat_done;
  logic              last_done;
  logic              cmd_accept;
  logic [OFF_W-1:0]  next_off;
  logic [LEN_W-1:0]  cnt_inc;

  assign beat_done = addr_valid_q & addr_ready;
  assign last_done = beat_done & addr_last_q;

`ifdef ADDR_SEQ_GEN_B2B_EN
  assign cmd_ready = (state_q == IDLE) | ((state_q == RUN) & last_done);
`else
  assign cmd_ready = (state_q == IDLE);
`endif

  assign cmd_accept = cmd_valid & cmd_ready;
  // Offset arithmetic is confined to OFF_W bits so a wrap never carries into the bank.
  assign next_off   = addr_q[OFF_W-1:0] + OFF_W'(stride_q);
  assign cnt_inc    = cnt_q + LEN_W'(1);

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    stride_d     = stride_q;
    addr_valid_d = addr_valid_q;
    addr_last_d  = addr_last_q;

    if (cfg_we) begin
      table_d[cfg_idx] = cfg_data;
    end

    if (last_done) begin
      state_d      = IDLE;
      addr_valid_d = 1'b0;
      addr_last_d  = 1'b0;
    end else if (beat_done) begin
      addr_d      = {addr_q[ADDR_W-1:OFF_W], next_off};
      cnt_d       = cnt_inc;
      addr_last_d = (cnt_inc == len_q);
    end

    // Reads table_q, so a same-cycle cfg write to this index is not yet visible.
    if (cmd_accept) begin
      state_d      = RUN;
      addr_d       = table_q[cmd_idx];
      len_d        = cmd_len;
      stride_d     = cmd_stride;
      cnt_d        = '0;
      addr_valid_d = 1'b1;
      addr_last_d  = (cmd_len == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      stride_q     <= '0;
      addr_valid_q <= 1'b0;
      addr_last_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= ADDR_W'(i);
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      stride_q     <= stride_d;
      addr_valid_q <= addr_valid_d;
      addr_last_q  <= addr_last_d;
      table_q      <= table_d;
    end
  end

  assign addr_valid = addr_valid_q;
  assign addr_last  = addr_last_q;
  assign addr       = addr_q;
  assign busy       = (state_q == RUN);

endmodule
